matram_lane_sequencer: RTL and testbench

Parametrised, multi-lane address sequencer for the Matrix Acceleration Unit's MatRAM. It supersedes the single-lane controller. On `mau_start` it walks a rows×cols matrix stored row-major at a programmed base address. Each cycle it emits up to LANES element addresses, in row-major or column-major (transposed) order, with per-lane validity, stall support and a done pulse. It sits between the MAU sequencing logic and the LANES read ports of the MatRAM banks.

---
 rtl/matram_lane_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_matram_lane_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matram_lane_sequencer.sv
// -----------------------------------------------------------------------------
// matram_lane_sequencer
//
// Multi-lane address sequencer for the MatRAM of the Matrix Acceleration Unit.
// On mau_start it walks a (rows_m1+1) x (cols_m1+1) matrix stored row-major at
// the programmed base address. Every non-stalled RUN cycle it presents one
// group of up to LANES element addresses, either along a row (mode=0) or down
// a column (mode=1). Lanes past the end of the current line are masked.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous active-high reset
//   set_address  in IDLE, loads address_in into the base register
//   address_in   base address of element (0,0)
//   rows_m1      row count minus one, captured at an accepted start
//   cols_m1      column count minus one, captured at an accepted start
//   mode         0 = row-major walk, 1 = column-major walk
//   mau_start    start pulse, accepted only in IDLE
//   stall        holds the presented group and suspends advance (RUN only)
//   address_out  lane k address at bits [k*ADDR_W +: ADDR_W], 0 when masked
//   lane_valid   per-lane valid
//   addr_valid   a group is presented this cycle
//   busy         high in RUN and DONE
//   done         one-cycle completion pulse (DONE state)
//
// Address arithmetic is modulo 2^ADDR_W and uses only adders: the line base
// is advanced by a stride per line, the group base by a stride per group, and
// the per-lane offsets (k or k*cols) are built once at start by an adder chain.
// -----------------------------------------------------------------------------
module matram_lane_sequencer #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 4,
    parameter int DIM_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      set_address,
    input  logic [ADDR_W-1:0]         address_in,
    input  logic [DIM_W-1:0]          rows_m1,
    input  logic [DIM_W-1:0]          cols_m1,
    input  logic                      mode,
    input  logic                      mau_start,
    input  logic                      stall,
    output logic [LANES*ADDR_W-1:0]   address_out,
    output logic [LANES-1:0]          lane_valid,
    output logic                      addr_valid,
    output logic                      busy,
    output logic                      done
);

    // Inner index must hold (largest inner index + LANES) without wrapping.
    localparam int IDX_W = DIM_W + $clog2(LANES + 1) + 1;

    localparam logic [ADDR_W-1:0]       ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]       ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]        IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]        IDX_LANES = IDX_W'(LANES);
    localparam logic [DIM_W-1:0]        DIM_ZERO  = {DIM_W{1'b0}};
    localparam logic [DIM_W-1:0]        DIM_ONE   = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [LANES*ADDR_W-1:0] OUT_ZERO  = {(LANES*ADDR_W){1'b0}};
    localparam logic [LANES-1:0]        LANE_ZERO = {LANES{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ---------------------------------------------------------------- state
    state_t                 state_r;
    logic [ADDR_W-1:0]      base_r;
    logic [DIM_W-1:0]       outer_max_r;
    logic [DIM_W-1:0]       inner_max_r;
    logic [DIM_W-1:0]       outer_r;
    logic [IDX_W-1:0]       inner_r;
    logic [ADDR_W-1:0]      line_addr_r;     // address of inner index 0 on this line
    logic [ADDR_W-1:0]      grp_addr_r;      // address of lane 0 of the presented group
    logic [ADDR_W-1:0]      outer_stride_r;  // line-to-line step
    logic [ADDR_W-1:0]      inner_stride_r;  // group-to-group step within a line
    logic [ADDR_W-1:0]      lane_off_r [LANES];
    logic [LANES*ADDR_W-1:0] address_out_r;
    logic [LANES-1:0]       lane_valid_r;
    logic                   addr_valid_r;
    logic                   busy_r;
    logic                   done_r;

    // ------------------------------------------------------- combinational
    logic [ADDR_W-1:0]      cols_s;
    logic [ADDR_W-1:0]      unit_s;
    logic [ADDR_W-1:0]      base_eff_s;
    logic [ADDR_W-1:0]      start_off_s [LANES];
    logic [ADDR_W-1:0]      start_inner_stride_s;
    logic [ADDR_W-1:0]      start_outer_stride_s;
    logic [DIM_W-1:0]       start_inner_max_s;
    logic [DIM_W-1:0]       start_outer_max_s;

    logic                   line_end_s;
    logic                   last_grp_s;
    logic [DIM_W-1:0]       nxt_outer_s;
    logic [IDX_W-1:0]       nxt_inner_s;
    logic [ADDR_W-1:0]      nxt_line_s;
    logic [ADDR_W-1:0]      nxt_grp_s;
    logic [DIM_W-1:0]       sel_max_s;
    logic [ADDR_W-1:0]      sel_off_s [LANES];
    logic [LANES*ADDR_W-1:0] nxt_addr_s;
    logic [LANES-1:0]       nxt_valid_s;

    assign address_out = address_out_r;
    assign lane_valid  = lane_valid_r;
    assign addr_valid  = addr_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;

    // Start configuration: strides, limits and lane offsets derived from the inputs.
    always_comb begin
        logic [ADDR_W-1:0] acc;
        cols_s = ADDR_W'(cols_m1) + ADDR_ONE;
        if (mode) begin
            // Column-major: lanes step down rows (stride cols), lines step by one column.
            unit_s               = cols_s;
            start_outer_stride_s = ADDR_ONE;
            start_inner_max_s    = rows_m1;
            start_outer_max_s    = cols_m1;
        end else begin
            // Row-major: lanes are adjacent elements, lines step by one row.
            unit_s               = ADDR_ONE;
            start_outer_stride_s = cols_s;
            start_inner_max_s    = cols_m1;
            start_outer_max_s    = rows_m1;
        end
        // Adder chain: offset k = k*unit, and the group stride = LANES*unit.
        acc = ADDR_ZERO;
        for (int k = 0; k < LANES; k++) begin
            start_off_s[k] = acc;
            acc            = acc + unit_s;
        end
        start_inner_stride_s = acc;
        if (set_address) begin
            // A simultaneous set_address is used by the run it accompanies.
            base_eff_s = address_in;
        end else begin
            base_eff_s = base_r;
        end
    end

    // Next-group position: first group on start, otherwise advance along the walk.
    always_comb begin
        line_end_s = (inner_r + IDX_LANES) > IDX_W'(inner_max_r);
        last_grp_s = line_end_s && (outer_r == outer_max_r);
        if (state_r == ST_IDLE) begin
            nxt_outer_s = DIM_ZERO;
            nxt_inner_s = IDX_ZERO;
            nxt_line_s  = base_eff_s;
            nxt_grp_s   = base_eff_s;
            sel_max_s   = start_inner_max_s;
            sel_off_s   = start_off_s;
        end else begin
            sel_max_s = inner_max_r;
            sel_off_s = lane_off_r;
            if (line_end_s) begin
                nxt_outer_s = outer_r + DIM_ONE;
                nxt_inner_s = IDX_ZERO;
                nxt_line_s  = line_addr_r + outer_stride_r;
                nxt_grp_s   = line_addr_r + outer_stride_r;
            end else begin
                nxt_outer_s = outer_r;
                nxt_inner_s = inner_r + IDX_LANES;
                nxt_line_s  = line_addr_r;
                nxt_grp_s   = grp_addr_r + inner_stride_r;
            end
        end
    end

    // Lane addresses and masks for the next group; masked lanes read as zero.
    always_comb begin
        nxt_addr_s  = OUT_ZERO;
        nxt_valid_s = LANE_ZERO;
        for (int k = 0; k < LANES; k++) begin
            if ((nxt_inner_s + IDX_W'(k)) <= IDX_W'(sel_max_s)) begin
                nxt_valid_s[k]                  = 1'b1;
                nxt_addr_s[k*ADDR_W +: ADDR_W]  = nxt_grp_s + sel_off_s[k];
            end else begin
                nxt_valid_s[k]                  = 1'b0;
                nxt_addr_s[k*ADDR_W +: ADDR_W]  = ADDR_ZERO;
            end
        end
    end

    // Control FSM with registered outputs and walk-position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            base_r         <= ADDR_ZERO;
            outer_max_r    <= DIM_ZERO;
            inner_max_r    <= DIM_ZERO;
            outer_r        <= DIM_ZERO;
            inner_r        <= IDX_ZERO;
            line_addr_r    <= ADDR_ZERO;
            grp_addr_r     <= ADDR_ZERO;
            outer_stride_r <= ADDR_ZERO;
            inner_stride_r <= ADDR_ZERO;
            for (int k = 0; k < LANES; k++) begin
                lane_off_r[k] <= ADDR_ZERO;
            end
            address_out_r  <= OUT_ZERO;
            lane_valid_r   <= LANE_ZERO;
            addr_valid_r   <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (set_address) begin
                        base_r <= address_in;
                    end
                    if (mau_start) begin
                        state_r        <= ST_RUN;
                        outer_max_r    <= start_outer_max_s;
                        inner_max_r    <= start_inner_max_s;
                        outer_stride_r <= start_outer_stride_s;
                        inner_stride_r <= start_inner_stride_s;
                        lane_off_r     <= start_off_s;
                        outer_r        <= nxt_outer_s;
                        inner_r        <= nxt_inner_s;
                        line_addr_r    <= nxt_line_s;
                        grp_addr_r     <= nxt_grp_s;
                        address_out_r  <= nxt_addr_s;
                        lane_valid_r   <= nxt_valid_s;
                        addr_valid_r   <= 1'b1;
                        busy_r         <= 1'b1;
                        done_r         <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // A stall leaves every register, and so every output, untouched.
                    if (!stall) begin
                        if (last_grp_s) begin
                            state_r       <= ST_DONE;
                            address_out_r <= OUT_ZERO;
                            lane_valid_r  <= LANE_ZERO;
                            addr_valid_r  <= 1'b0;
                            done_r        <= 1'b1;
                        end else begin
                            outer_r       <= nxt_outer_s;
                            inner_r       <= nxt_inner_s;
                            line_addr_r   <= nxt_line_s;
                            grp_addr_r    <= nxt_grp_s;
                            address_out_r <= nxt_addr_s;
                            lane_valid_r  <= nxt_valid_s;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    address_out_r <= OUT_ZERO;
                    lane_valid_r  <= LANE_ZERO;
                    addr_valid_r  <= 1'b0;
                    busy_r        <= 1'b0;
                    done_r        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matram_lane_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for matram_lane_sequencer. A directed vector table gives hand
// computed first/last groups and run lengths; every presented group is also
// compared with a reference walk computed directly from base + r*cols + c.
// Randomised runs (random base, sizes, mode, stall) use the same reference.
// -----------------------------------------------------------------------------
module tb_matram_lane_sequencer;

    localparam int ADDR_W = 10;
    localparam int LANES  = 4;
    localparam int DIM_W  = 4;
    localparam int AW_ALL = LANES * ADDR_W;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 set_address;
    logic [ADDR_W-1:0]    address_in;
    logic [DIM_W-1:0]     rows_m1;
    logic [DIM_W-1:0]     cols_m1;
    logic                 mode;
    logic                 mau_start;
    logic                 stall;
    logic [AW_ALL-1:0]    address_out;
    logic [LANES-1:0]     lane_valid;
    logic                 addr_valid;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    matram_lane_sequencer #(.ADDR_W(ADDR_W), .LANES(LANES), .DIM_W(DIM_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .set_address (set_address),
        .address_in  (address_in),
        .rows_m1     (rows_m1),
        .cols_m1     (cols_m1),
        .mode        (mode),
        .mau_start   (mau_start),
        .stall       (stall),
        .address_out (address_out),
        .lane_valid  (lane_valid),
        .addr_valid  (addr_valid),
        .busy        (busy),
        .done        (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] model_base;
    logic [AW_ALL-1:0] exp_a_q [$];
    logic [LANES-1:0]  exp_v_q [$];
    logic [AW_ALL-1:0] obs_first_a, obs_last_a;
    logic [LANES-1:0]  obs_first_v, obs_last_v;
    int                obs_valid_cycles;

    typedef struct {
        logic        do_set;
        logic [9:0]  base;
        logic [3:0]  rm1;
        logic [3:0]  cm1;
        logic        m;
        int          stall_grp;
        int          stall_len;
        bit          inject;
        logic [AW_ALL-1:0] first_a;
        logic [LANES-1:0]  first_v;
        logic [AW_ALL-1:0] last_a;
        logic [LANES-1:0]  last_v;
        int          valid_cycles;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW_ALL-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    endfunction

    function automatic vec_t mk(input logic s, input int b, input int r, input int c, input logic m,
                                input int sg, input int sl, input bit inj,
                                input logic [AW_ALL-1:0] fa, input logic [LANES-1:0] fv,
                                input logic [AW_ALL-1:0] la, input logic [LANES-1:0] lv, input int vc);
        vec_t v;
        v.do_set = s; v.base = 10'(b); v.rm1 = 4'(r); v.cm1 = 4'(c); v.m = m;
        v.stall_grp = sg; v.stall_len = sl; v.inject = inj;
        v.first_a = fa; v.first_v = fv; v.last_a = la; v.last_v = lv; v.valid_cycles = vc;
        return v;
    endfunction

    // Reference walk: every group in order, addresses from base + r*cols + c.
    task automatic build_model(input logic [ADDR_W-1:0] b, input int rm1, input int cm1, input logic m);
        int ncols, outer_n, inner_n, r, c, e;
        logic [AW_ALL-1:0] ga;
        logic [LANES-1:0]  gv;
        exp_a_q.delete();
        exp_v_q.delete();
        ncols   = cm1 + 1;
        outer_n = m ? cm1 + 1 : rm1 + 1;
        inner_n = m ? rm1 + 1 : cm1 + 1;
        for (int o = 0; o < outer_n; o++) begin
            for (int i = 0; i < inner_n; i += LANES) begin
                ga = {AW_ALL{1'b0}};
                gv = {LANES{1'b0}};
                for (int k = 0; k < LANES; k++) begin
                    if (i + k < inner_n) begin
                        r = m ? i + k : o;
                        c = m ? o : i + k;
                        e = (int'(b) + r * ncols + c) % (1 << ADDR_W);
                        ga[k*ADDR_W +: ADDR_W] = e[ADDR_W-1:0];
                        gv[k] = 1'b1;
                    end
                end
                exp_a_q.push_back(ga);
                exp_v_q.push_back(gv);
            end
        end
    endtask

    // One complete run: start, check each presented group, DONE cycle and return to IDLE.
    task automatic run_seq(input logic do_set, input logic [9:0] b, input logic [3:0] rm1,
                           input logic [3:0] cm1, input logic m, input int sg, input int sl,
                           input bit rnd, input bit inj);
        int  gi, cyc, ng, held;
        bit  st;
        @(negedge clk);
        set_address = do_set; address_in = b; rows_m1 = rm1; cols_m1 = cm1; mode = m;
        mau_start = 1'b1; stall = 1'b0;
        if (do_set) model_base = b;
        build_model(model_base, int'(rm1), int'(cm1), m);
        ng = exp_a_q.size();
        @(negedge clk);
        set_address = 1'b0; mau_start = 1'b0;
        gi = 0; cyc = 0; held = 0; obs_valid_cycles = 0;
        while (gi < ng && cyc < 4000) begin
            if (addr_valid === 1'b1) obs_valid_cycles++;
            chk("run_addr_valid", addr_valid, 1);
            chk("run_busy", busy, 1);
            chk("run_done_low", done, 0);
            chk("run_address_out", address_out, exp_a_q[gi]);
            chk("run_lane_valid", lane_valid, exp_v_q[gi]);
            if (cyc == 0) begin obs_first_a = address_out; obs_first_v = lane_valid; end
            if (gi == ng - 1) begin obs_last_a = address_out; obs_last_v = lane_valid; end
            st = 1'b0;
            if (gi == sg && held < sl) begin st = 1'b1; held++; end
            else if (rnd && $urandom_range(3) == 0) st = 1'b1;
            if (inj && cyc == 0) begin
                mau_start = 1'b1; set_address = 1'b1; address_in = 10'd7;
            end else begin
                mau_start = 1'b0; set_address = 1'b0;
            end
            stall = st;
            if (!st) gi++;
            @(negedge clk);
            cyc++;
        end
        stall = 1'b0; mau_start = 1'b0; set_address = 1'b0;
        if (cyc >= 4000) chk("run_timeout", cyc, 0);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_addr_valid", addr_valid, 0);
        chk("done_lane_valid", lane_valid, 0);
        chk("done_address_out", address_out, 0);
        if (inj) mau_start = 1'b1;   // a start in DONE must be dropped
        @(negedge clk);
        mau_start = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_addr_valid", addr_valid, 0);
    endtask

    initial begin
        reset = 1'b1; set_address = 1'b0; address_in = 10'd0; rows_m1 = 4'd0; cols_m1 = 4'd0;
        mode = 1'b0; mau_start = 1'b0; stall = 1'b0; model_base = 10'd0;

        vecs[0] = mk(1'b1, 44, 1, 3, 1'b0, -1, 0, 1'b0,
                     pk(44, 45, 46, 47), 4'b1111, pk(48, 49, 50, 51), 4'b1111, 2);
        vecs[1] = mk(1'b1, 100, 2, 1, 1'b1, -1, 0, 1'b0,
                     pk(100, 102, 104, 0), 4'b0111, pk(101, 103, 105, 0), 4'b0111, 2);
        vecs[2] = mk(1'b1, 8, 0, 5, 1'b0, -1, 0, 1'b0,
                     pk(8, 9, 10, 11), 4'b1111, pk(12, 13, 0, 0), 4'b0011, 2);
        vecs[3] = mk(1'b1, 1022, 0, 3, 1'b0, -1, 0, 1'b0,
                     pk(1022, 1023, 0, 1), 4'b1111, pk(1022, 1023, 0, 1), 4'b1111, 1);
        vecs[4] = mk(1'b1, 44, 1, 3, 1'b0, 1, 3, 1'b0,
                     pk(44, 45, 46, 47), 4'b1111, pk(48, 49, 50, 51), 4'b1111, 5);
        vecs[5] = mk(1'b1, 44, 1, 3, 1'b0, -1, 0, 1'b1,
                     pk(44, 45, 46, 47), 4'b1111, pk(48, 49, 50, 51), 4'b1111, 2);
        vecs[6] = mk(1'b0, 0, 1, 3, 1'b0, -1, 0, 1'b0,
                     pk(44, 45, 46, 47), 4'b1111, pk(48, 49, 50, 51), 4'b1111, 2);
        vecs[7] = mk(1'b1, 5, 0, 0, 1'b0, -1, 0, 1'b0,
                     pk(5, 0, 0, 0), 4'b0001, pk(5, 0, 0, 0), 4'b0001, 1);

        repeat (3) @(negedge clk);
        chk("reset_address_out", address_out, 0);
        chk("reset_lane_valid", lane_valid, 0);
        chk("reset_addr_valid", addr_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_seq(vecs[i].do_set, vecs[i].base, vecs[i].rm1, vecs[i].cm1, vecs[i].m,
                    vecs[i].stall_grp, vecs[i].stall_len, 1'b0, vecs[i].inject);
            chk($sformatf("vec%0d_first_addr", i), obs_first_a, vecs[i].first_a);
            chk($sformatf("vec%0d_first_valid", i), obs_first_v, vecs[i].first_v);
            chk($sformatf("vec%0d_last_addr", i), obs_last_a, vecs[i].last_a);
            chk($sformatf("vec%0d_last_valid", i), obs_last_v, vecs[i].last_v);
            chk($sformatf("vec%0d_valid_cycles", i), obs_valid_cycles, vecs[i].valid_cycles);
        end

        // Reset in the middle of a run, then a start with no set_address uses base 0
        @(negedge clk);
        set_address = 1'b1; address_in = 10'd300; rows_m1 = 4'd1; cols_m1 = 4'd3; mode = 1'b0;
        mau_start = 1'b1;
        @(negedge clk);
        set_address = 1'b0; mau_start = 1'b0;
        chk("midrun_pre_valid", addr_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_reset_address_out", address_out, 0);
        chk("midrun_reset_lane_valid", lane_valid, 0);
        chk("midrun_reset_addr_valid", addr_valid, 0);
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_done", done, 0);
        reset = 1'b0;
        model_base = 10'd0;
        run_seq(1'b0, 10'd0, 4'd1, 4'd3, 1'b0, -1, 0, 1'b0, 1'b0);
        chk("post_reset_first_addr", obs_first_a, pk(0, 1, 2, 3));
        chk("post_reset_last_addr", obs_last_a, pk(4, 5, 6, 7));

        // Randomised runs against the reference walk
        for (int n = 0; n < 40; n++) begin
            run_seq(1'($urandom_range(1)), 10'($urandom_range(1023)), 4'($urandom_range(15)),
                    4'($urandom_range(15)), 1'($urandom_range(1)), -1, 0, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
